// File: rtl/smi_frame_arbiter_x4.sv
// rtl/smi_frame_arbiter_x4.sv - round-robin, frame-atomic 4:1 SMI flit arbiter
//
// Merges four SMI requester streams onto one SMI output. A granted port keeps
// the output until its end-of-frame flit (EOFC != 0) has been accepted. The
// output side is decoupled by a 2-entry FIFO.
//
// Ports:
//   clk, arst_n               clock, asynchronous active-low reset
//   smiInReady/Eofc/Data      per-port flit valid, EOFC and data (port i = slice i)
//   smiInStop                 per-port backpressure
//   smiOutReady/Eofc/Data     merged output flit valid, EOFC and data
//   smiOutStop                output backpressure
//   portEnable                per-port arbitration enable, sampled only while idle
//   grantValid, grantIndex    frame lock status and locked port (index holds when idle)
//   frameCount                frames fully forwarded, wraps

module smi_frame_arbiter_x4 #(
  parameter int FlitWidth  = 4,
  parameter int CountWidth = 16
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic [3:0]               smiInReady,
  input  logic [31:0]              smiInEofc,
  input  logic [4*FlitWidth*8-1:0] smiInData,
  output logic [3:0]               smiInStop,
  output logic                     smiOutReady,
  output logic [7:0]               smiOutEofc,
  output logic [FlitWidth*8-1:0]   smiOutData,
  input  logic                     smiOutStop,
  input  logic [3:0]               portEnable,
  output logic                     grantValid,
  output logic [1:0]               grantIndex,
  output logic [CountWidth-1:0]    frameCount
);

  localparam int DataWidth = FlitWidth * 8;

  typedef enum logic {
    IDLE,
    LOCK
  } arbStateT;

  arbStateT              state;
  logic [1:0]            rrPtr;
  logic [3:0]            candidates;
  logic [1:0]            pick;
  logic                  pickFound;
  logic [7:0]            grantEofc;
  logic [DataWidth-1:0]  grantData;
  logic                  push;
  logic                  pop;

  // 2-entry output FIFO
  logic [DataWidth-1:0]  bufData [2];
  logic [7:0]            bufEofc [2];
  logic [1:0]            bufCount;
  logic                  wrPtr;
  logic                  rdPtr;

  assign candidates = smiInReady & portEnable;

  // Round-robin search starting just after the last granted port; the
  // fourth probe wraps back to rrPtr itself so a lone requester is never starved.
  always_comb begin
    pick      = rrPtr;
    pickFound = 1'b0;
    for (int k = 1; k < 5; k++) begin
      logic [1:0] probe;
      probe = rrPtr + 2'(k);
      if (!pickFound && candidates[probe]) begin
        pick      = probe;
        pickFound = 1'b1;
      end
    end
  end

  // Input mux for the locked port.
  always_comb begin
    grantEofc = '0;
    grantData = '0;
    for (int i = 0; i < 4; i++) begin
      if (grantIndex == 2'(i)) begin
        grantEofc = smiInEofc[8*i +: 8];
        grantData = smiInData[DataWidth*i +: DataWidth];
      end
    end
  end

  // Only the locked port may be released, and only while the FIFO has room.
  // Stop is derived purely from registered state, so it never depends on
  // same-cycle Ready.
  always_comb begin
    smiInStop = 4'hF;
    if (state == LOCK && bufCount != 2'd2) begin
      smiInStop[grantIndex] = 1'b0;
    end
  end

  assign push = (state == LOCK) && smiInReady[grantIndex] && !smiInStop[grantIndex];
  assign pop  = smiOutReady && !smiOutStop;

  assign smiOutReady = (bufCount != 2'd0);
  assign smiOutData  = bufData[rdPtr];
  assign smiOutEofc  = bufEofc[rdPtr];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state      <= IDLE;
      rrPtr      <= 2'd3;
      grantValid <= 1'b0;
      grantIndex <= 2'd0;
      frameCount <= '0;
      bufCount   <= 2'd0;
      wrPtr      <= 1'b0;
      rdPtr      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pickFound) begin
            grantIndex <= pick;
            grantValid <= 1'b1;
            state      <= LOCK;
          end
        end
        LOCK: begin
          // End of frame: release the lock and rotate priority past this port.
          if (push && grantEofc != 8'd0) begin
            rrPtr      <= grantIndex;
            grantValid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (push) begin
        wrPtr <= ~wrPtr;
      end
      if (pop) begin
        rdPtr <= ~rdPtr;
      end
      case ({push, pop})
        2'b10:   bufCount <= bufCount + 2'd1;
        2'b01:   bufCount <= bufCount - 2'd1;
        default: bufCount <= bufCount;
      endcase

      // A frame counts as forwarded once its last flit leaves the block.
      if (pop && smiOutEofc != 8'd0) begin
        frameCount <= frameCount + CountWidth'(1);
      end
    end
  end

  // FIFO storage needs no reset; entries are only observed when bufCount != 0.
  always_ff @(posedge clk) begin
    if (push) begin
      bufData[wrPtr] <= grantData;
      bufEofc[wrPtr] <= grantEofc;
    end
  end

endmodule

// File: tb/tb_smi_frame_arbiter_x4.sv
// tb/tb_smi_frame_arbiter_x4.sv - directed self-checking bench for smi_frame_arbiter_x4

module tb_smi_frame_arbiter_x4;

  localparam int FW = 4;
  localparam int CW = 4;
  localparam int DW = FW * 8;

  logic            clk;
  logic            arst_n;
  logic [3:0]      inReady;
  logic [31:0]     inEofc;
  logic [4*DW-1:0] inData;
  logic [3:0]      smiInStop;
  logic            smiOutReady;
  logic [7:0]      smiOutEofc;
  logic [DW-1:0]   smiOutData;
  logic            outStop;
  logic [3:0]      portEnable;
  logic            grantValid;
  logic [1:0]      grantIndex;
  logic [CW-1:0]   frameCount;

  smi_frame_arbiter_x4 #(.FlitWidth(FW), .CountWidth(CW)) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .smiInReady  (inReady),
    .smiInEofc   (inEofc),
    .smiInData   (inData),
    .smiInStop   (smiInStop),
    .smiOutReady (smiOutReady),
    .smiOutEofc  (smiOutEofc),
    .smiOutData  (smiOutData),
    .smiOutStop  (outStop),
    .portEnable  (portEnable),
    .grantValid  (grantValid),
    .grantIndex  (grantIndex),
    .frameCount  (frameCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testsRun = 0;
  int testsFailed = 0;

  logic [3:0] srcEn;
  int srcIdx [4];
  int srcLen [4];
  int srcLeft [4];
  int srcFrame [4];

  logic [DW-1:0] outLog [$];
  int grantLog [$];
  int lowLog [$];
  int lowRun;
  logic prevGv;

  function automatic logic [31:0] flit(input int p, input int f, input int i);
    return {8'(p), 8'(f), 8'(i), 8'hA5};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      inReady[i]       = srcEn[i];
      inEofc[8*i +: 8] = (srcIdx[i] == srcLen[i] - 1) ? 8'(FW) : 8'h00;
      inData[DW*i +: DW] = flit(i, srcFrame[i], srcIdx[i]);
    end
  endtask

  task automatic clearAll();
    srcEn = 4'h0;
    for (int i = 0; i < 4; i++) begin
      srcIdx[i] = 0; srcLen[i] = 1; srcLeft[i] = 0; srcFrame[i] = 0;
    end
    outLog.delete(); grantLog.delete(); lowLog.delete();
    drive();
  endtask

  // One clock: record what transfers at this edge, then advance the sources.
  task automatic step();
    logic [3:0] xfer;
    xfer = inReady & ~smiInStop;
    if (smiOutReady && !outStop) outLog.push_back(smiOutData);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (xfer[i]) begin
        srcIdx[i]++;
        if (srcIdx[i] == srcLen[i]) begin
          srcIdx[i] = 0; srcFrame[i]++; srcLeft[i]--;
          if (srcLeft[i] == 0) srcEn[i] = 1'b0;
        end
      end
    end
    if (grantValid && !prevGv) begin
      grantLog.push_back(int'(grantIndex));
      lowLog.push_back(lowRun);
    end
    lowRun = grantValid ? 0 : lowRun + 1;
    prevGv = grantValid;
    drive();
  endtask

  task automatic waitGrant(input int bound, input string tag);
    int n = 0;
    while (!grantValid && n < bound) begin step(); n++; end
    check(tag, 64'(n < bound), 64'(1));
  endtask

  task automatic runUntilDone(input int bound, input string tag);
    int n = 0;
    while ((srcEn != 4'h0 || smiOutReady || grantValid) && n < bound) begin step(); n++; end
    check(tag, 64'(n < bound), 64'(1));
  endtask

  task automatic resetPulse();
    arst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1'b1;
    prevGv = 1'b0;
    lowRun = 0;
    clearAll();
  endtask

  function automatic logic [31:0] logAt(input int k);
    return (k < outLog.size()) ? outLog[k] : 32'hDEADBEEF;
  endfunction

  initial begin
    arst_n = 1'b0; outStop = 1'b0; portEnable = 4'hF;
    inReady = '0; inEofc = '0; inData = '0;
    prevGv = 1'b0; lowRun = 0;
    clearAll();
    repeat (3) @(posedge clk);
    #1;
    check("rst_outReady", 64'(smiOutReady), 64'(0));
    check("rst_inStop", 64'(smiInStop), 64'(4'hF));
    check("rst_grantValid", 64'(grantValid), 64'(0));
    check("rst_grantIndex", 64'(grantIndex), 64'(0));
    check("rst_frameCount", 64'(frameCount), 64'(0));
    arst_n = 1'b1;

    // 1: single 3-flit frame on port 1
    srcEn[1] = 1'b1; srcLen[1] = 3; srcLeft[1] = 1; drive();
    step();
    check("t1_grantValid", 64'(grantValid), 64'(1));
    check("t1_grantIndex", 64'(grantIndex), 64'(1));
    check("t1_inStop", 64'(smiInStop), 64'(4'b1101));
    step();
    check("t1_out0_ready", 64'(smiOutReady), 64'(1));
    check("t1_out0_data", 64'(smiOutData), 64'(flit(1, 0, 0)));
    check("t1_out0_eofc", 64'(smiOutEofc), 64'(0));
    step();
    check("t1_out1_data", 64'(smiOutData), 64'(flit(1, 0, 1)));
    step();
    check("t1_out2_data", 64'(smiOutData), 64'(flit(1, 0, 2)));
    check("t1_out2_eofc", 64'(smiOutEofc), 64'(FW));
    check("t1_gv_low", 64'(grantValid), 64'(0));
    check("t1_inStop_idle", 64'(smiInStop), 64'(4'hF));
    step();
    check("t1_out_empty", 64'(smiOutReady), 64'(0));
    check("t1_frameCount", 64'(frameCount), 64'(1));

    // 2: all four ports request 2-flit frames, port 0 twice
    resetPulse();
    srcEn = 4'hF;
    for (int i = 0; i < 4; i++) begin srcLen[i] = 2; srcLeft[i] = 1; end
    srcLeft[0] = 2;
    drive();
    runUntilDone(80, "t2_timeout");
    check("t2_grants", 64'(grantLog.size()), 64'(5));
    for (int k = 0; k < 5; k++)
      check($sformatf("t2_grant%0d", k), 64'((k < grantLog.size()) ? grantLog[k] : -1), 64'(k % 4));
    for (int k = 1; k < 5; k++)
      check($sformatf("t2_idle%0d", k), 64'((k < lowLog.size()) ? lowLog[k] : -1), 64'(1));
    check("t2_outCount", 64'(outLog.size()), 64'(10));
    for (int k = 0; k < 10; k++)
      check($sformatf("t2_flit%0d", k), 64'(logAt(k)), 64'(flit((k / 2) % 4, k / 8, k % 2)));
    check("t2_frameCount", 64'(frameCount), 64'(5));

    // 3: output stall of 5 cycles mid-frame on port 2
    clearAll();
    srcEn[2] = 1'b1; srcLen[2] = 6; srcLeft[2] = 1; drive();
    waitGrant(10, "t3_grant_timeout");
    check("t3_grantIndex", 64'(grantIndex), 64'(2));
    step();
    step();
    outStop = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("t3_hold_ready%0d", k), 64'(smiOutReady), 64'(1));
      check($sformatf("t3_hold_head%0d", k), 64'(smiOutData), 64'(flit(2, 0, 1)));
      check($sformatf("t3_full_stop%0d", k), 64'(smiInStop[2]), 64'(1));
    end
    outStop = 1'b0;
    runUntilDone(40, "t3_timeout");
    check("t3_outCount", 64'(outLog.size()), 64'(6));
    for (int k = 0; k < 6; k++)
      check($sformatf("t3_flit%0d", k), 64'(logAt(k)), 64'(flit(2, 0, k)));

    // 4: port 2 disabled; port 0 disabled mid-frame
    clearAll();
    portEnable = 4'b1011;
    srcEn[0] = 1'b1; srcLen[0] = 4; srcLeft[0] = 1;
    srcEn[2] = 1'b1; srcLen[2] = 2; srcLeft[2] = 1;
    drive();
    waitGrant(10, "t4_grant_timeout");
    check("t4_grantIndex", 64'(grantIndex), 64'(0));
    step();
    portEnable = 4'b1010;
    repeat (10) step();
    check("t4_grants", 64'(grantLog.size()), 64'(1));
    check("t4_outCount", 64'(outLog.size()), 64'(4));
    for (int k = 0; k < 4; k++)
      check($sformatf("t4_flit%0d", k), 64'(logAt(k)), 64'(flit(0, 0, k)));
    check("t4_idle_gv", 64'(grantValid), 64'(0));
    check("t4_idle_stop", 64'(smiInStop), 64'(4'hF));

    // 5: asynchronous reset mid-frame on port 3
    clearAll();
    portEnable = 4'hF;
    srcEn[3] = 1'b1; srcLen[3] = 4; srcLeft[3] = 1; drive();
    waitGrant(10, "t5_grant_timeout");
    check("t5_grantIndex", 64'(grantIndex), 64'(3));
    step();
    arst_n = 1'b0;
    #1;
    check("t5_async_ready", 64'(smiOutReady), 64'(0));
    check("t5_async_stop", 64'(smiInStop), 64'(4'hF));
    check("t5_async_gv", 64'(grantValid), 64'(0));
    check("t5_async_gi", 64'(grantIndex), 64'(0));
    check("t5_async_fc", 64'(frameCount), 64'(0));
    resetPulse();
    srcEn[0] = 1'b1; srcLeft[0] = 1;
    srcEn[3] = 1'b1; srcLeft[3] = 1;
    drive();
    waitGrant(10, "t5_regrant_timeout");
    check("t5_first_port0", 64'(grantIndex), 64'(0));
    runUntilDone(40, "t5_timeout");
    check("t5_second_port3", 64'((grantLog.size() > 1) ? grantLog[1] : -1), 64'(3));
    check("t5_frameCount", 64'(frameCount), 64'(2));

    // 6: 17 single-flit frames wrap a 4-bit counter
    resetPulse();
    srcEn[1] = 1'b1; srcLen[1] = 1; srcLeft[1] = 17; drive();
    runUntilDone(200, "t6_timeout");
    check("t6_outCount", 64'(outLog.size()), 64'(17));
    check("t6_frameCount_wrap", 64'(frameCount), 64'(1));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
